hazard_ctrl: RTL
================

Name: hazard_ctrl

Overview:
- Pipeline sequencer for the 5-stage MIPS core (IF, DE, EX, MEM, WB).
- Generates the per-latch enable and flush signals, including the decode-stage flush input on the decode interface.
- Arbitrates between I-cache misses, D-cache waits, load-use hazards, taken branches/jumps and halt.
- Keeps sticky halt state and saturating performance counters for stall and flush cycles.

Parameters:
CNT_W, 32, width of the stall_cycles and flush_cycles counters.

Ports:
CLK  input  1  core clock, rising edge.
RST  input  1  asynchronous, active-high reset.
ihit  input  1  instruction fetch completed this cycle.
dhit  input  1  data access completed this cycle.
mem_dREN  input  1  load in MEM stage.
mem_dWEN  input  1  store in MEM stage.
ex_dREN  input  1  instruction in EX is a load.
ex_regDst  input  5  destination register of the instruction in EX.
de_rs  input  5  rs of the instruction in DE.
de_rt  input  5  rt of the instruction in DE.
de_uses_rt  input  1  DE instruction reads rt (R-type, store, branch).
br_taken  input  1  EX resolved a taken branch or jump (PCSrc not sequential).
wb_halt  input  1  halt instruction is in WB.
pc_en  output  1  PC update enable.
ifde_en  output  1  IF/DE latch enable (drives decode deen).
deex_en  output  1  DE/EX latch enable.
exmem_en  output  1  EX/MEM latch enable.
memwb_en  output  1  MEM/WB latch enable.
ifde_flush  output  1  IF/DE latch loads a NOP (drives decode flush).
deex_flush  output  1  DE/EX latch loads a NOP.
halt  output  1  core halted, sticky.
stall_cycles  output  CNT_W  count of cycles with pc_en=0 while not halted.
flush_cycles  output  CNT_W  count of cycles with ifde_flush or deex_flush asserted.

Behaviour:
- FSM states:
  - RUN: normal operation.
  - DWAIT: a data access in MEM is outstanding.
  - HALTED: core stopped.
- Reset (RST=1, asynchronous): state=RUN, halt=0, both counters=0.
- Combinational definitions:
  - dreq = mem_dREN | mem_dWEN.
  - loaduse = ex_dREN & (ex_regDst!=0) & ((ex_regDst==de_rs) | (de_uses_rt & ex_regDst==de_rt)).
- Transitions:
  - RUN -> DWAIT when dreq & !dhit.
  - DWAIT -> RUN when dhit.
  - Any state -> HALTED when wb_halt.
  - HALTED is left only by RST.
  - wb_halt has priority over every other transition.
- Outputs by priority, highest first. All enables default to 1, all flushes to 0.
  1. HALTED, or wb_halt this cycle: all enables=0, flushes=0, halt=1. halt is a registered, sticky output set on the edge where wb_halt=1.
  2. dreq & !dhit (in RUN or DWAIT): all five enables=0, flushes=0. Full freeze; br_taken and loaduse stay asserted by the frozen latches and are serviced on the release cycle.
  3. br_taken: pc_en=1, ifde_flush=1, deex_flush=1, and the other enables=1. The PC loads the target and two bubbles are inserted. loaduse is ignored because the DE instruction is squashed.
  4. loaduse: pc_en=0, ifde_en=0, deex_flush=1, exmem_en=memwb_en=1. This gives one bubble; loaduse self-clears next cycle once the load has moved to MEM.
  5. !ihit: pc_en=0, ifde_flush=1, and downstream latches advance.
- Whenever a flush is asserted, the corresponding latch enable is also 1, so the NOP is actually loaded.
- A cycle where dhit=1 while in DWAIT behaves as RUN (rules 3-5 apply).
- A simultaneous dhit and !ihit is resolved by rule 5 alone.
- Counters:
  - stall_cycles increments on each cycle with pc_en=0 and state!=HALTED.
  - flush_cycles increments on each cycle with (ifde_flush | deex_flush).
  - Both saturate at all-ones and never wrap.
  - Both freeze in HALTED.
- No output latency beyond combinational for enables/flushes; only halt, state and the counters are registered.
- RST asserted mid-freeze or mid-halt returns to RUN on the same edge. Outputs follow RUN rules immediately after reset deasserts.

Test Plan:
- Reset then ihit=1, no hazards for 10 cycles -> all enables=1, flushes=0, stall_cycles=0, flush_cycles=0, halt=0.
- ex_dREN=1, ex_regDst=5, de_rs=5 for one cycle -> pc_en=0, ifde_en=0, deex_flush=1 for exactly 1 cycle; stall_cycles=1.
- Same as above with ex_regDst=0 -> no stall; with de_rt=5, de_uses_rt=0 -> no stall.
- mem_dREN=1, dhit=0 for 4 cycles, then dhit=1 with br_taken=1 held -> 4 cycles of all enables=0. On the dhit cycle: pc_en=1, ifde_flush=deex_flush=1. Then stall_cycles=4, flush_cycles=1, state=RUN.
- br_taken=1 and loaduse=1 together -> branch wins: pc_en=1, both flushes=1, no loaduse stall.
- wb_halt=1 pulse during a D-cache wait -> halt=1 from next edge and held with all enables=0 after wb_halt drops. Counters frozen. RST pulse -> halt=0, counters=0.
- Force stall_cycles near its maximum (CNT_W=4: 15 stall cycles, then 3 more) -> value stays 15.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline sequencer for the 5-stage core (IF, DE, EX, MEM, WB).
//
// Decides which pipeline latches advance and which load a NOP. It resolves
// D-cache waits, load-use hazards, taken branches/jumps, I-cache misses and
// halt. Halt is sticky. Two saturating counters track stall and flush cycles.
//
// Ports
//   CLK, RST      core clock (rising edge), asynchronous active-high reset
//   ihit, dhit    fetch / data access completed this cycle
//   mem_dREN/WEN  load / store in MEM
//   ex_dREN       EX instruction is a load; ex_regDst is its destination
//   de_rs, de_rt  DE source registers; de_uses_rt says whether rt is read
//   br_taken      EX resolved a taken branch or jump
//   wb_halt       halt instruction in WB
//   *_en          latch enables (pc, IF/DE, DE/EX, EX/MEM, MEM/WB)
//   *_flush       IF/DE and DE/EX load a NOP
//   halt          registered, sticky halt indication
//   stall_cycles  cycles with pc_en=0 while not halted (saturating)
//   flush_cycles  cycles with any flush asserted (saturating)
//
// state  | meaning
// RUN    | normal operation
// DWAIT  | data access in MEM outstanding
// HALTED | core stopped until reset
module hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             mem_dREN,
  input  logic             mem_dWEN,
  input  logic             ex_dREN,
  input  logic [4:0]       ex_regDst,
  input  logic [4:0]       de_rs,
  input  logic [4:0]       de_rt,
  input  logic             de_uses_rt,
  input  logic             br_taken,
  input  logic             wb_halt,
  output logic             pc_en,
  output logic             ifde_en,
  output logic             deex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifde_flush,
  output logic             deex_flush,
  output logic             halt,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_cycles
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DWAIT  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t state;

  logic dreq;
  logic dstall;
  logic loaduse;

  assign dreq   = mem_dREN | mem_dWEN;
  assign dstall = dreq & ~dhit;

  // r0 never carries a real dependency, so a load targeting it is ignored.
  assign loaduse = ex_dREN & (ex_regDst != 5'd0) &
                   ((ex_regDst == de_rs) | (de_uses_rt & (ex_regDst == de_rt)));

  // Enables/flushes are combinational so a hazard is handled in the same
  // cycle it is seen. Every flush keeps its latch enable high so the NOP loads.
  always_comb begin
    pc_en      = 1'b1;
    ifde_en    = 1'b1;
    deex_en    = 1'b1;
    exmem_en   = 1'b1;
    memwb_en   = 1'b1;
    ifde_flush = 1'b0;
    deex_flush = 1'b0;
    if ((state == HALTED) || wb_halt || dstall) begin
      // Full freeze: a pending branch or load-use is held by the frozen
      // latches and gets serviced on the release cycle.
      pc_en    = 1'b0;
      ifde_en  = 1'b0;
      deex_en  = 1'b0;
      exmem_en = 1'b0;
      memwb_en = 1'b0;
    end else if (br_taken) begin
      // DE instruction is squashed, so any load-use against it is moot.
      ifde_flush = 1'b1;
      deex_flush = 1'b1;
    end else if (loaduse) begin
      pc_en      = 1'b0;
      ifde_en    = 1'b0;
      deex_flush = 1'b1;
    end else if (!ihit) begin
      pc_en      = 1'b0;
      ifde_flush = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state        <= RUN;
      halt         <= 1'b0;
      stall_cycles <= '0;
      flush_cycles <= '0;
    end else begin
      if (state != HALTED) begin
        if (!pc_en && (stall_cycles != {CNT_W{1'b1}}))
          stall_cycles <= stall_cycles + CNT_W'(1);
        if ((ifde_flush || deex_flush) && (flush_cycles != {CNT_W{1'b1}}))
          flush_cycles <= flush_cycles + CNT_W'(1);
      end
      if (wb_halt) begin
        state <= HALTED;
        halt  <= 1'b1;
      end else begin
        case (state)
          RUN:     if (dstall) state <= DWAIT;
          DWAIT:   if (dhit)   state <= RUN;
          HALTED:  state <= HALTED;
          default: state <= RUN;
        endcase
      end
    end
  end

endmodule
